// File: rtl/ni_flit_injector_pkg.sv
// Shared definitions for the NI flit injector: FSM state type, width helpers
// and flit field positions.
package ni_flit_injector_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  function automatic int max1(input int n);
    return (n < 32'sd1) ? 32'sd1 : n;
  endfunction

  function automatic int flit_width(input int v, input int fpay);
    return 32'sd2 + v + fpay;
  endfunction

  function automatic int head_pos(input int fw);
    return fw - 32'sd1;
  endfunction

  function automatic int tail_pos(input int fw);
    return fw - 32'sd2;
  endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Downstream buffer-space counter for one VC; saturates at B so a spurious
// credit can never report more space than the router buffer holds.
module ni_credit_counter
  import ni_flit_injector_pkg::*;
#(
  parameter int B = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dec,
  input  logic inc,
  output logic avail
);

  localparam int CW = log2(B + 1);

  logic [CW-1:0] count_r;

  // Credit count: send consumes, credit_in returns, both together cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= CW'(B);
    end else begin
      case ({dec, inc})
        2'b10:   count_r <= (count_r != {CW{1'b0}}) ? count_r - CW'(1) : count_r;
        2'b01:   count_r <= (count_r != CW'(B)) ? count_r + CW'(1) : count_r;
        default: count_r <= count_r;
      endcase
    end
  end

  assign avail = (count_r != {CW{1'b0}});

endmodule

// File: rtl/ni_flit_injector.sv
// Network-interface transmitter: splits core packet requests into head/body/tail
// flits, picks an output VC round-robin and tracks per-VC credits.
module ni_flit_injector
  import ni_flit_injector_pkg::*;
#(
  parameter int V      = 2,
  parameter int B      = 4,
  parameter int NX     = 5,
  parameter int NY     = 5,
  parameter int C      = 2,
  parameter int Fpay   = 32,
  parameter int MAXPKT = 16,
  parameter logic [C*V-1:0] CLASS_SETTING = {(C*V){1'b1}},
  localparam int Xw = log2(NX),
  localparam int Yw = log2(NY),
  localparam int Cw = max1(log2(C)),
  localparam int Lw = log2(MAXPKT + 1),
  localparam int Fw = flit_width(V, Fpay)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Xw-1:0]   current_x,
  input  logic [Yw-1:0]   current_y,
  input  logic            pkt_valid,
  output logic            pkt_ready,
  input  logic [Xw-1:0]   pkt_dest_x,
  input  logic [Yw-1:0]   pkt_dest_y,
  input  logic [Cw-1:0]   pkt_class,
  input  logic [Lw-1:0]   pkt_len,
  input  logic [Fpay-1:0] data_in,
  input  logic            data_valid,
  output logic            data_ready,
  output logic [Fw-1:0]   flit_out,
  output logic            flit_out_we,
  input  logic [V-1:0]    credit_in,
  output logic            busy
);

  localparam int Vw = max1(log2(V));

  state_t          state_r;
  state_t          state_nxt_s;
  logic [V-1:0]    vc_r;
  logic [Vw-1:0]   vc_idx_r;
  logic [Vw-1:0]   rr_ptr_r;
  logic [Lw-1:0]   remaining_r;

  logic [V-1:0]    avail_s;
  logic [V-1:0]    class_mask_s;
  logic [V-1:0]    elig_s;
  logic            any_elig_s;
  logic [V-1:0]    pick_s;
  logic [Vw-1:0]   pick_idx_s;
  logic            pick_found_s;
  int              rr_pos_s;
  logic [Lw-1:0]   eff_len_s;
  logic [Fpay-1:0] head_payload_s;

  logic            issue_s;
  logic            head_s;
  logic            tail_s;
  logic [V-1:0]    issue_vc_s;
  logic [Vw-1:0]   issue_idx_s;
  logic [Fpay-1:0] payload_s;

  for (genvar v = 0; v < V; v++) begin : g_credit
    ni_credit_counter #(
      .B(B)
    ) u_credit (
      .clk   (clk),
      .reset (reset),
      .dec   (issue_vc_s[v]),
      .inc   (credit_in[v]),
      .avail (avail_s[v])
    );
  end

  // VCs the requesting class is allowed to use.
  always_comb begin
    class_mask_s = {V{1'b0}};
    for (int c = 0; c < C; c++) begin
      if (pkt_class == Cw'(c)) begin
        class_mask_s = CLASS_SETTING[c*V +: V];
      end else begin
        class_mask_s = class_mask_s;
      end
    end
  end

  assign elig_s     = class_mask_s & avail_s;
  assign any_elig_s = |elig_s;

  // Round-robin pick: search starts at the VC after the last one that sent a tail.
  always_comb begin
    pick_s       = {V{1'b0}};
    pick_idx_s   = {Vw{1'b0}};
    pick_found_s = 1'b0;
    rr_pos_s     = 0;
    for (int i = 0; i < V; i++) begin
      rr_pos_s = (int'(rr_ptr_r) + i) % V;
      if (!pick_found_s && elig_s[rr_pos_s]) begin
        pick_found_s       = 1'b1;
        pick_s[rr_pos_s]   = 1'b1;
        pick_idx_s         = Vw'(rr_pos_s);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // A zero-length request is sent as a single head+tail flit.
  assign eff_len_s      = (pkt_len == {Lw{1'b0}}) ? Lw'(1) : pkt_len;
  assign head_payload_s = Fpay'({pkt_class, current_y, current_x, pkt_dest_y, pkt_dest_x});

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (issue_s && !tail_s) begin
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (issue_s && tail_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Issue decision and flit contents for this cycle.
  always_comb begin
    pkt_ready   = 1'b0;
    data_ready  = 1'b0;
    issue_s     = 1'b0;
    head_s      = 1'b0;
    tail_s      = 1'b0;
    issue_vc_s  = {V{1'b0}};
    issue_idx_s = {Vw{1'b0}};
    payload_s   = {Fpay{1'b0}};
    case (state_r)
      IDLE: begin
        if (pkt_valid && any_elig_s) begin
          pkt_ready   = 1'b1;
          issue_s     = 1'b1;
          head_s      = 1'b1;
          tail_s      = (eff_len_s == Lw'(1));
          issue_vc_s  = pick_s;
          issue_idx_s = pick_idx_s;
          payload_s   = head_payload_s;
        end else begin
          pkt_ready = 1'b0;
        end
      end
      SEND: begin
        if (data_valid && ((vc_r & avail_s) != {V{1'b0}})) begin
          data_ready  = 1'b1;
          issue_s     = 1'b1;
          tail_s      = (remaining_r == Lw'(1));
          issue_vc_s  = vc_r;
          issue_idx_s = vc_idx_r;
          payload_s   = data_in;
        end else begin
          data_ready = 1'b0;
        end
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
  end

  // Packet context: chosen VC, flits still to send, round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc_r        <= {V{1'b0}};
      vc_idx_r    <= {Vw{1'b0}};
      remaining_r <= {Lw{1'b0}};
      rr_ptr_r    <= {Vw{1'b0}};
    end else begin
      if (issue_s && head_s) begin
        vc_r        <= pick_s;
        vc_idx_r    <= pick_idx_s;
        remaining_r <= eff_len_s - Lw'(1);
      end else if (issue_s) begin
        remaining_r <= remaining_r - Lw'(1);
      end else begin
        remaining_r <= remaining_r;
      end
      if (issue_s && tail_s) begin
        rr_ptr_r <= (issue_idx_s == Vw'(V - 1)) ? {Vw{1'b0}} : issue_idx_s + Vw'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Registered flit port; data holds between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_out    <= {Fw{1'b0}};
      flit_out_we <= 1'b0;
    end else begin
      flit_out_we <= issue_s;
      if (issue_s) begin
        flit_out[head_pos(Fw)]   <= head_s;
        flit_out[tail_pos(Fw)]   <= tail_s;
        flit_out[Fpay +: V]      <= issue_vc_s;
        flit_out[Fpay-1:0]       <= payload_s;
      end else begin
        flit_out <= flit_out;
      end
    end
  end

  assign busy = (state_r == SEND);

endmodule

// File: tb/tb_ni_flit_injector.sv
// Directed self-checking bench for ni_flit_injector; a second instance with a
// restrictive class-to-VC mask covers class steering.
module tb_ni_flit_injector;

  localparam int Xw = 3;
  localparam int Yw = 3;
  localparam int Cw = 1;
  localparam int Lw = 5;
  localparam int Fw = 36;

  logic          clk;
  logic          reset;
  logic [Xw-1:0] current_x;
  logic [Yw-1:0] current_y;
  logic          pkt_valid;
  logic [Xw-1:0] pkt_dest_x;
  logic [Yw-1:0] pkt_dest_y;
  logic [Cw-1:0] pkt_class;
  logic [Lw-1:0] pkt_len;
  logic [31:0]   data_in;
  logic          data_valid;
  logic [1:0]    credit_in;

  logic          pkt_ready, data_ready, flit_out_we, busy;
  logic [Fw-1:0] flit_out;
  logic          m_pkt_ready, m_data_ready, m_flit_out_we, m_busy;
  logic [Fw-1:0] m_flit_out;

  int checks = 0;
  int errors = 0;

  ni_flit_injector dut (
    .clk(clk), .reset(reset), .current_x(current_x), .current_y(current_y),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dest_x(pkt_dest_x),
    .pkt_dest_y(pkt_dest_y), .pkt_class(pkt_class), .pkt_len(pkt_len),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .flit_out(flit_out), .flit_out_we(flit_out_we), .credit_in(credit_in), .busy(busy)
  );

  ni_flit_injector #(.CLASS_SETTING(4'b1001)) dut_m (
    .clk(clk), .reset(reset), .current_x(current_x), .current_y(current_y),
    .pkt_valid(pkt_valid), .pkt_ready(m_pkt_ready), .pkt_dest_x(pkt_dest_x),
    .pkt_dest_y(pkt_dest_y), .pkt_class(pkt_class), .pkt_len(pkt_len),
    .data_in(data_in), .data_valid(data_valid), .data_ready(m_data_ready),
    .flit_out(m_flit_out), .flit_out_we(m_flit_out_we), .credit_in(credit_in), .busy(m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pkt_valid = 1'b0; data_valid = 1'b0; credit_in = 2'b00;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic drive_pkt(input logic [2:0] dx, input logic [2:0] dy, input logic c, input logic [4:0] len);
    pkt_dest_x = dx; pkt_dest_y = dy; pkt_class = c; pkt_len = len; pkt_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pkt_valid = 1'b0; data_valid = 1'b0; credit_in = 2'b00;
    current_x = 3'd1; current_y = 3'd1; data_in = 32'd0;
    pkt_dest_x = 3'd0; pkt_dest_y = 3'd0; pkt_class = 1'b0; pkt_len = 5'd0;
    #2;
    checks++;
    if (flit_out !== 36'h0 || flit_out_we !== 1'b0 || busy !== 1'b0 || pkt_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got flit=%h we=%b busy=%b ready=%b expected 0/0/0/0", flit_out, flit_out_we, busy, pkt_ready);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    drive_pkt(3'd3, 3'd2, 1'b0, 5'd1);
    #1;
    checks++;
    if (pkt_ready !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got ready=%b data_ready=%b expected 1/0", pkt_ready, data_ready);
    end
    step();
    pkt_valid = 1'b0;
    checks++;
    if (flit_out_we !== 1'b1 || flit_out !== 36'hD_0000_0253 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_flit: got we=%b flit=%h busy=%b expected 1 d00000253 0", flit_out_we, flit_out, busy);
    end
    step();
    checks++;
    if (flit_out_we !== 1'b0 || flit_out !== 36'hD_0000_0253) begin
      errors++;
      $display("FAIL single_hold: got we=%b flit=%h expected 0 d00000253", flit_out_we, flit_out);
    end
  endtask

  // Class 1 packet lands on VC1: round robin moved past VC0 after the previous tail.
  task automatic test_multi();
    logic [35:0] exp_body [3];
    exp_body[0] = 36'h2_0000_000A; exp_body[1] = 36'h2_0000_000B; exp_body[2] = 36'h6_0000_000C;
    drive_pkt(3'd2, 3'd4, 1'b1, 5'd4);
    data_valid = 1'b1; data_in = 32'hA;
    #1;
    checks++;
    if (pkt_ready !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL multi_ready: got ready=%b data_ready=%b expected 1/0", pkt_ready, data_ready);
    end
    step();
    pkt_valid = 1'b0;
    checks++;
    if (flit_out_we !== 1'b1 || flit_out !== 36'hA_0000_1262 || busy !== 1'b1) begin
      errors++;
      $display("FAIL multi_head: got we=%b flit=%h busy=%b expected 1 a00001262 1", flit_out_we, flit_out, busy);
    end
    for (int i = 0; i < 3; i++) begin
      data_in = 32'hA + 32'(i);
      #1;
      checks++;
      if (data_ready !== 1'b1) begin
        errors++;
        $display("FAIL multi_data_ready%0d: got %b expected 1", i, data_ready);
      end
      step();
      checks++;
      if (flit_out_we !== 1'b1 || flit_out !== exp_body[i]) begin
        errors++;
        $display("FAIL multi_body%0d: got we=%b flit=%h expected 1 %h", i, flit_out_we, flit_out, exp_body[i]);
      end
    end
    data_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL multi_idle: got busy=%b expected 0", busy);
    end
  endtask

  // VC0 holds 3 credits and VC1 none: a 3-flit packet drains VC0, then nothing is accepted.
  task automatic test_residual();
    logic [35:0] exp_f [3];
    exp_f[0] = 36'h9_0000_0240; exp_f[1] = 36'h1_0000_0055; exp_f[2] = 36'h5_0000_0055;
    drive_pkt(3'd0, 3'd0, 1'b0, 5'd3);
    data_valid = 1'b1; data_in = 32'h55;
    #1;
    checks++;
    if (pkt_ready !== 1'b1) begin
      errors++;
      $display("FAIL residual_ready: got %b expected 1", pkt_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      pkt_valid = 1'b0;
      checks++;
      if (flit_out_we !== 1'b1 || flit_out !== exp_f[i]) begin
        errors++;
        $display("FAIL residual_flit%0d: got we=%b flit=%h expected 1 %h", i, flit_out_we, flit_out, exp_f[i]);
      end
    end
    data_valid = 1'b0;
    drive_pkt(3'd0, 3'd0, 1'b0, 5'd1);
    #1;
    checks++;
    if (pkt_ready !== 1'b0) begin
      errors++;
      $display("FAIL residual_class0_blocked: got %b expected 0", pkt_ready);
    end
    pkt_class = 1'b1;
    #1;
    checks++;
    if (pkt_ready !== 1'b0) begin
      errors++;
      $display("FAIL residual_class1_blocked: got %b expected 0", pkt_ready);
    end
    pkt_valid = 1'b0;
    step();
  endtask

  task automatic test_credit_stall();
    do_reset();
    drive_pkt(3'd0, 3'd0, 1'b0, 5'd6);
    data_valid = 1'b1; data_in = 32'd1;
    #1;
    checks++;
    if (pkt_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready: got %b expected 1", pkt_ready);
    end
    step();
    pkt_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      data_in = 32'(i);
      step();
      checks++;
      if (flit_out_we !== 1'b1 || flit_out !== {4'h1, 32'(i)}) begin
        errors++;
        $display("FAIL stall_body%0d: got we=%b flit=%h expected 1 %h", i, flit_out_we, flit_out, {4'h1, 32'(i)});
      end
    end
    for (int k = 4; k <= 5; k++) begin
      data_in = 32'(k);
      #1;
      checks++;
      if (data_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_blocked%0d: got data_ready=%b busy=%b expected 0 1", k, data_ready, busy);
      end
      credit_in = 2'b01;
      #1;
      checks++;
      if (data_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_credit_same_cycle%0d: got data_ready=%b expected 0", k, data_ready);
      end
      step();
      credit_in = 2'b00;
      checks++;
      if (flit_out_we !== 1'b0) begin
        errors++;
        $display("FAIL stall_no_write%0d: got we=%b expected 0", k, flit_out_we);
      end
      step();
      checks++;
      if (flit_out_we !== 1'b1 || flit_out !== {(k == 5) ? 4'h5 : 4'h1, 32'(k)}) begin
        errors++;
        $display("FAIL stall_resume%0d: got we=%b flit=%h", k, flit_out_we, flit_out);
      end
    end
    data_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got busy=%b expected 0", busy);
    end
  endtask

  // Masked instance: VC0 at 1, a head issue and a VC0 credit in one cycle leave it at 1.
  task automatic test_credit_same_cycle();
    credit_in = 2'b01;
    step();
    credit_in = 2'b00;
    drive_pkt(3'd0, 3'd0, 1'b0, 5'd2);
    credit_in = 2'b01;
    #1;
    checks++;
    if (m_pkt_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_ready: got %b expected 1", m_pkt_ready);
    end
    step();
    credit_in = 2'b00; pkt_valid = 1'b0;
    checks++;
    if (m_flit_out_we !== 1'b1 || m_flit_out !== 36'h9_0000_0240) begin
      errors++;
      $display("FAIL same_cycle_head: got we=%b flit=%h expected 1 900000240", m_flit_out_we, m_flit_out);
    end
    data_valid = 1'b1; data_in = 32'h77;
    #1;
    checks++;
    if (m_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_count_kept: got data_ready=%b expected 1", m_data_ready);
    end
    step();
    data_valid = 1'b0;
    checks++;
    if (m_flit_out_we !== 1'b1 || m_flit_out !== 36'h5_0000_0077) begin
      errors++;
      $display("FAIL same_cycle_tail: got we=%b flit=%h expected 1 500000077", m_flit_out_we, m_flit_out);
    end
    drive_pkt(3'd0, 3'd0, 1'b0, 5'd1);
    #1;
    checks++;
    if (m_pkt_ready !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_empty: got ready=%b expected 0", m_pkt_ready);
    end
    pkt_valid = 1'b0;
    step();
  endtask

  // Masked instance: class steering, back-to-back heads, saturation at B.
  task automatic test_class_mask();
    logic        cls [6];
    cls[0] = 1'b0; cls[1] = 1'b1; cls[2] = 1'b0; cls[3] = 1'b1; cls[4] = 1'b0; cls[5] = 1'b0;
    do_reset();
    credit_in = 2'b11;
    step();
    credit_in = 2'b00;
    for (int i = 0; i < 6; i++) begin
      drive_pkt(3'd0, 3'd0, cls[i], 5'd1);
      #1;
      checks++;
      if (m_pkt_ready !== 1'b1) begin
        errors++;
        $display("FAIL class_ready%0d: got %b expected 1", i, m_pkt_ready);
      end
      step();
      checks++;
      if (m_flit_out_we !== 1'b1 || m_flit_out !== (cls[i] ? 36'hE_0000_1240 : 36'hD_0000_0240)) begin
        errors++;
        $display("FAIL class_flit%0d: got we=%b flit=%h class=%0d", i, m_flit_out_we, m_flit_out, cls[i]);
      end
    end
    drive_pkt(3'd0, 3'd0, 1'b0, 5'd1);
    #1;
    checks++;
    if (m_pkt_ready !== 1'b0) begin
      errors++;
      $display("FAIL class0_no_credit: got %b expected 0", m_pkt_ready);
    end
    pkt_class = 1'b1;
    #1;
    checks++;
    if (m_pkt_ready !== 1'b1) begin
      errors++;
      $display("FAIL class1_has_credit: got %b expected 1", m_pkt_ready);
    end
    pkt_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back_and_reset();
    do_reset();
    drive_pkt(3'd0, 3'd0, 1'b0, 5'd4);
    data_valid = 1'b0;
    step();
    pkt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (data_ready !== 1'b0) begin
        errors++;
        $display("FAIL gap_data_ready%0d: got %b expected 0", i, data_ready);
      end
      step();
      checks++;
      if (flit_out_we !== 1'b0) begin
        errors++;
        $display("FAIL gap_we%0d: got %b expected 0", i, flit_out_we);
      end
    end
    data_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data_in = 32'h11 * 32'(i);
      step();
      checks++;
      if (flit_out_we !== 1'b1 || flit_out !== {(i == 3) ? 4'h5 : 4'h1, 32'h11 * 32'(i)}) begin
        errors++;
        $display("FAIL gap_body%0d: got we=%b flit=%h", i, flit_out_we, flit_out);
      end
    end
    drive_pkt(3'd0, 3'd0, 1'b0, 5'd3);
    #1;
    checks++;
    if (pkt_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b expected 1", pkt_ready);
    end
    step();
    pkt_valid = 1'b0;
    checks++;
    if (flit_out_we !== 1'b1 || flit_out !== 36'hA_0000_0240) begin
      errors++;
      $display("FAIL b2b_head: got we=%b flit=%h expected 1 a00000240", flit_out_we, flit_out);
    end
    data_in = 32'h44;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (flit_out_we !== 1'b0 || flit_out !== 36'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got we=%b flit=%h busy=%b expected 0 0 0", flit_out_we, flit_out, busy);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (flit_out_we !== 1'b0) begin
        errors++;
        $display("FAIL after_reset_quiet%0d: got we=%b expected 0", i, flit_out_we);
      end
    end
    drive_pkt(3'd0, 3'd0, 1'b0, 5'd4);
    step();
    pkt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'hF0 + 32'(i);
      step();
      checks++;
      if (flit_out_we !== 1'b1 || flit_out[31:0] !== 32'hF0 + 32'(i)) begin
        errors++;
        $display("FAIL after_reset_credit%0d: got we=%b flit=%h", i, flit_out_we, flit_out);
      end
    end
    data_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_residual();
    test_credit_stall();
    test_credit_same_cycle();
    test_class_mask();
    test_back_to_back_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
